// File: rtl/conv_acc_prelu.sv
// Accumulates C_IN signed partial sums with guard bits, adds the channel bias,
// applies PReLU with a per-channel slope and saturates to one WIDTH-bit output sample.
//
// state | meaning
// ACC   | accepting partial sums; in_ready high
// CALC  | bias add, PReLU, saturation; result registered
// OUT   | result presented until out_ready
module conv_acc_prelu #(
    parameter int WIDTH = 32,
    parameter int FBITS = 24,
    parameter int C_IN  = 16,
    parameter int GUARD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] bias,
    input  logic [WIDTH-1:0] alpha,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sat
);

    localparam int AW = WIDTH + GUARD;
    localparam int PW = AW + WIDTH;
    localparam int CW = (C_IN > 1) ? $clog2(C_IN) : 1;

    localparam logic [1:0] ST_ACC  = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(C_IN - 1);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_bias;
    logic [WIDTH-1:0] r_alpha;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_sat;

    logic                 w_accept;
    logic [AW-1:0]        w_in_ext;
    logic [AW-1:0]        w_sum;
    logic signed [PW-1:0] w_sum_ext;
    logic signed [PW-1:0] w_alpha_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_res;
    logic                 w_hi;
    logic                 w_lo;

    assign in_ready  = (r_state == ST_ACC);
    assign w_accept  = in_valid && in_ready;
    assign w_in_ext  = {{GUARD{in_data[WIDTH-1]}}, in_data};

    // Guard bits make the bias add and the full-width product overflow-free.
    assign w_sum       = r_acc + {{GUARD{r_bias[WIDTH-1]}}, r_bias};
    assign w_sum_ext   = {{WIDTH{w_sum[AW-1]}}, w_sum};
    assign w_alpha_ext = {{AW{r_alpha[WIDTH-1]}}, r_alpha};
    assign w_prod      = w_sum_ext * w_alpha_ext;
    assign w_res       = w_sum[AW-1] ? (w_prod >>> FBITS) : w_sum_ext;
    assign w_hi        = (w_res > SAT_MAX);
    assign w_lo        = (w_res < SAT_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACC;
            r_count     <= '0;
            r_acc       <= '0;
            r_bias      <= '0;
            r_alpha     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        if (r_count == '0) begin
                            r_acc   <= w_in_ext;
                            r_bias  <= bias;
                            r_alpha <= alpha;
                        end else begin
                            r_acc <= r_acc + w_in_ext;
                        end
                        if (r_count == LAST) begin
                            r_count <= '0;
                            r_state <= ST_CALC;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    if (w_hi) begin
                        r_out_data <= SAT_MAX[WIDTH-1:0];
                    end else if (w_lo) begin
                        r_out_data <= SAT_MIN[WIDTH-1:0];
                    end else begin
                        r_out_data <= w_res[WIDTH-1:0];
                    end
                    r_out_sat   <= w_hi || w_lo;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_conv_acc_prelu.sv
// Directed bench for conv_acc_prelu (C_IN=4, Q8.24): an arithmetic reference model
// feeds a scoreboard that a per-cycle monitor checks against the DUT outputs.
module tb_conv_acc_prelu;

    localparam int WIDTH = 32;
    localparam int FBITS = 24;
    localparam int C_IN  = 4;
    localparam int GUARD = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bias;
    logic [31:0] alpha;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sat;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] exp_q[$];

    conv_acc_prelu #(
        .WIDTH(WIDTH), .FBITS(FBITS), .C_IN(C_IN), .GUARD(GUARD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bias(bias), .alpha(alpha),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact rational arithmetic: sum, bias, then floor(s*alpha/2^FBITS) for s<0, then clamp.
    function automatic logic [32:0] model(input logic [31:0] bt[4], input logic [31:0] b,
                                          input logic [31:0] a);
        logic signed [127:0] s, p, q, d;
        d = 128'sd16777216;
        s = 0;
        for (int i = 0; i < 4; i++) s = s + $signed(bt[i]);
        s = s + $signed(b);
        if (s >= 0) begin
            q = s;
        end else begin
            p = s * $signed(a);
            q = p / d;
            if (p < 0 && q * d != p) q = q - 1;
        end
        if (q > 128'sd2147483647)  return {1'b1, 32'h7FFFFFFF};
        if (q < -128'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, q[31:0]};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat until accepted; returns 1 ns after the accepting edge.
    task automatic beat(input logic [31:0] d, input logic [31:0] b, input logic [31:0] a);
        logic ok;
        int   n;
        in_data  = d;
        bias     = b;
        alpha    = a;
        in_valid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("beat_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
    endtask

    task automatic send_sample(input logic [31:0] bt[4], input logic [31:0] b,
                               input logic [31:0] a, input logic bub,
                               input logic [31:0] lit, input logic lsat);
        logic [32:0] e;
        e = model(bt, b, a);
        chk("model_pin_data", e[31:0], lit);
        chk("model_pin_sat", {31'd0, e[32]}, {31'd0, lsat});
        for (int i = 0; i < 4; i++) begin
            beat(bt[i], b, a);
            if (bub && i < 3) begin
                bias  = 32'h55555555;
                alpha = 32'hAAAAAAAA;
                idle(i + 1);
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        chk("latency_calc_low", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("latency_out_high", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: score each new result, check hold stability and handshake-driven in_ready.
    initial begin
        logic        prev_v  = 1'b0;
        logic        prev_hs = 1'b0;
        logic [31:0] held_d  = '0;
        logic        held_s  = 1'b0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v  = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (out_valid) begin
                    chk("in_ready_low_in_out", {31'd0, in_ready}, 32'd0);
                    if (!prev_v) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_out_valid", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", out_data, e[31:0]);
                            chk("out_sat", {31'd0, out_sat}, {31'd0, e[32]});
                        end
                        held_d = out_data;
                        held_s = out_sat;
                    end else begin
                        chk("hold_data", out_data, held_d);
                        chk("hold_sat", {31'd0, out_sat}, {31'd0, held_s});
                    end
                end
                if (prev_hs) chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
                prev_hs = out_valid && out_ready;
                prev_v  = out_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bt[4];
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        bias      = '0;
        alpha     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        idle(1);

        bt = '{32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000};
        send_sample(bt, 32'h00800000, 32'h12345678, 1'b0, 32'h04800000, 1'b0);

        bt = '{32'hFF000000, 32'hFF000000, 32'hFF000000, 32'hFF000000};
        send_sample(bt, 32'h00000000, 32'h00400000, 1'b0, 32'hFF000000, 1'b0);

        bt = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000};
        send_sample(bt, 32'h00000000, 32'h00400000, 1'b0, 32'hFFFFFFFF, 1'b0);

        bt = '{32'h64000000, 32'h64000000, 32'h64000000, 32'h64000000};
        send_sample(bt, 32'h00000000, 32'h00400000, 1'b0, 32'h7FFFFFFF, 1'b1);

        bt = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        send_sample(bt, 32'h00000000, 32'h01000000, 1'b0, 32'h80000000, 1'b1);

        // Backpressure: result held while the next sample's first beat waits unconsumed.
        out_ready = 1'b0;
        bt = '{32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000};
        send_sample(bt, 32'h00800000, 32'h00400000, 1'b0, 32'h04800000, 1'b0);
        fork
            begin
                idle(4);
                out_ready = 1'b1;
            end
        join_none
        bt = '{32'h00100000, 32'hFFF00000, 32'h00200000, 32'h00300000};
        send_sample(bt, 32'hFF000000, 32'h00800000, 1'b0, 32'hFFA80000, 1'b0);

        bt = '{32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000};
        send_sample(bt, 32'h00800000, 32'h00400000, 1'b1, 32'h04800000, 1'b0);

        beat(32'h01000000, 32'h00800000, 32'h00400000);
        beat(32'h01000000, 32'h00800000, 32'h00400000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        #3;
        rst_n = 1'b1;
        idle(1);
        send_sample(bt, 32'h00800000, 32'h00400000, 1'b0, 32'h04800000, 1'b0);

        idle(10);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
